// File: rtl/if_pkg.sv
// Shared types and constants for the RV32IM instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR_C          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: load a fetched instruction, hold, or insert a bubble.
module if_id_pipeline_register import if_pkg::*; #(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc_plus4_r;
    logic        valid_r;

    // Load wins over bubble; a bubble keeps the PC fields of the previous entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= 32'h0000_0000;
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (load) begin
            pc_r       <= next_pc;
            instr_r    <= next_instr;
            pc_plus4_r <= pc_plus4(next_pc);
            valid_r    <= 1'b1;
        end else if (bubble) begin
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
        end else begin
            pc_r       <= pc_r;
            instr_r    <= instr_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end
    end

    assign if_pc          = pc_r;
    assign if_instruction = instr_r;
    assign if_pc_plus4    = pc_plus4_r;
    assign if_valid       = valid_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, skid buffer, IF/ID register.
// Optional stall counter output enabled by defining IF_PERF_COUNTERS_EN.
module if_fetch_stage import if_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic [31:0] IF_PC_PLUS4,
`ifdef IF_PERF_COUNTERS_EN
    output logic [31:0] PERF_FETCH_STALLS,
`endif
    output logic        IF_VALID
);

    if_state_e   state_r;
    if_state_e   state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] target_r;
    logic [31:0] target_s;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_instr_r;
    logic        buf_load_s;
    logic        buf_clear_s;
    logic        ifid_load_s;
    logic        ifid_bubble_s;
    logic [31:0] ifid_pc_s;
    logic [31:0] ifid_instr_s;

    // PC stays put during DRAIN, so it is also the address of the read being drained.
    assign IMEM_ADDR = pc_r;
    assign IMEM_READ = (state_r != HOLD) && !RST;

    // Next-state, PC, skid-buffer and IF/ID control; a redirect overrides everything.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        target_s      = target_r;
        buf_load_s    = 1'b0;
        buf_clear_s   = 1'b0;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        ifid_pc_s     = pc_r;
        ifid_instr_s  = IMEM_READDATA;
        if (BRANCH_TAKEN) begin
            ifid_bubble_s = 1'b1;
            buf_clear_s   = 1'b1;
            if ((state_r != HOLD) && IMEM_BUSYWAIT) begin
                target_s = BRANCH_TARGET;
                state_s  = DRAIN;
            end else begin
                pc_s    = BRANCH_TARGET;
                state_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        if (!STALL) begin
                            ifid_load_s = 1'b1;
                            pc_s        = pc_plus4(pc_r);
                        end else begin
                            buf_load_s = 1'b1;
                            state_s    = HOLD;
                        end
                    end else begin
                        ifid_bubble_s = !STALL;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        ifid_load_s  = 1'b1;
                        ifid_pc_s    = buf_pc_r;
                        ifid_instr_s = buf_instr_r;
                        pc_s         = pc_plus4(pc_r);
                        buf_clear_s  = 1'b1;
                        state_s      = FETCH;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DRAIN: begin
                    ifid_bubble_s = !STALL;
                    if (!IMEM_BUSYWAIT) begin
                        pc_s    = target_r;
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // FSM, PC, saved redirect target and skid buffer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= FETCH;
            pc_r        <= RESET_VECTOR;
            target_r    <= 32'h0000_0000;
            buf_pc_r    <= 32'h0000_0000;
            buf_instr_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            target_r <= target_s;
            if (buf_load_s) begin
                buf_pc_r    <= pc_r;
                buf_instr_r <= IMEM_READDATA;
            end else if (buf_clear_s) begin
                buf_pc_r    <= 32'h0000_0000;
                buf_instr_r <= 32'h0000_0000;
            end else begin
                buf_pc_r    <= buf_pc_r;
                buf_instr_r <= buf_instr_r;
            end
        end
    end

    if_id_pipeline_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk            (CLK),
        .rst            (RST),
        .load           (ifid_load_s),
        .bubble         (ifid_bubble_s),
        .next_pc        (ifid_pc_s),
        .next_instr     (ifid_instr_s),
        .if_pc          (IF_PC),
        .if_instruction (IF_INSTRUCTION),
        .if_pc_plus4    (IF_PC_PLUS4),
        .if_valid       (IF_VALID)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_cnt_r;

    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (IMEM_READ && IMEM_BUSYWAIT && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign PERF_FETCH_STALLS = perf_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized self-checking bench for if_fetch_stage against a behavioural fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_stalls;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain variables describing what the fetch stage should hold.
    logic [31:0] m_pc;
    bit          m_buffered;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_word;
    bit          m_draining;
    logic [31:0] m_redirect;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    bit          e_valid;
    logic [31:0] m_stalls;

    if_fetch_stage dut (
        .CLK            (clk),
        .RST            (rst),
        .STALL          (stall),
        .BRANCH_TAKEN   (branch_taken),
        .BRANCH_TARGET  (branch_target),
        .IMEM_ADDR      (imem_addr),
        .IMEM_READ      (imem_read),
        .IMEM_READDATA  (imem_readdata),
        .IMEM_BUSYWAIT  (imem_busywait),
        .IF_PC          (if_pc),
        .IF_INSTRUCTION (if_instruction),
        .IF_PC_PLUS4    (if_pc_plus4),
`ifdef IF_PERF_COUNTERS_EN
        .PERF_FETCH_STALLS (perf_fetch_stalls),
`endif
        .IF_VALID       (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A00_1234;
    endfunction

    assign imem_readdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0000_0000;
        m_buffered = 1'b0;
        m_buf_pc   = 32'h0;
        m_buf_word = 32'h0;
        m_draining = 1'b0;
        m_redirect = 32'h0;
        e_pc       = 32'h0;
        e_instr    = NOP;
        e_pc4      = 32'h0;
        e_valid    = 1'b0;
        m_stalls   = 32'h0;
    endtask

    task automatic deliver(input logic [31:0] pc, input logic [31:0] word);
        e_pc    = pc;
        e_instr = word;
        e_pc4   = pc + 32'd4;
        e_valid = 1'b1;
    endtask

    task automatic insert_bubble();
        e_instr = NOP;
        e_valid = 1'b0;
    endtask

    // One clock of the model, given the inputs about to be sampled.
    task automatic model_step();
        bit requesting;
        requesting = !m_buffered;
        if (requesting && imem_busywait && m_stalls != 32'hFFFF_FFFF)
            m_stalls = m_stalls + 32'd1;
        if (branch_taken) begin
            insert_bubble();
            if (requesting && imem_busywait) begin
                m_redirect = branch_target;
                m_draining = 1'b1;
            end else begin
                m_pc       = branch_target;
                m_draining = 1'b0;
            end
            m_buffered = 1'b0;
        end else if (m_draining) begin
            if (!stall) insert_bubble();
            if (!imem_busywait) begin
                m_pc       = m_redirect;
                m_draining = 1'b0;
            end
        end else if (m_buffered) begin
            if (!stall) begin
                deliver(m_buf_pc, m_buf_word);
                m_pc       = m_pc + 32'd4;
                m_buffered = 1'b0;
            end
        end else if (!imem_busywait) begin
            if (!stall) begin
                deliver(m_pc, mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end else begin
                m_buf_pc   = m_pc;
                m_buf_word = mem_word(m_pc);
                m_buffered = 1'b1;
            end
        end else if (!stall) begin
            insert_bubble();
        end
    endtask

    task automatic check_all();
        check("imem_read", {31'd0, imem_read}, {31'd0, (!rst && !m_buffered)});
        if (imem_read) check("imem_addr", imem_addr, m_pc);
        check("if_pc", if_pc, e_pc);
        check("if_instruction", if_instruction, e_instr);
        check("if_pc_plus4", if_pc_plus4, e_pc4);
        check("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
`ifdef IF_PERF_COUNTERS_EN
        check("perf_fetch_stalls", perf_fetch_stalls, m_stalls);
`endif
    endtask

    function automatic logic [31:0] pick_target();
        int sel;
        sel = $urandom_range(5, 0);
        case (sel)
            0: return 32'hFFFF_FFFC;
            1: return 32'hFFFF_FFF8;
            2: return 32'h0000_0100;
            3: return 32'h0000_0200;
            default: return {$urandom_range(32'h3FFF, 32'h0), 2'b00};
        endcase
    endfunction

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_busywait = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        model_step();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check_all();
            if (rst) begin
                rst = 1'b0;
            end else if (cyc > 40 && $urandom_range(199, 0) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                continue;
            end
            if (cyc < 16) begin
                stall         = 1'b0;
                branch_taken  = 1'b0;
                imem_busywait = (cyc >= 8 && cyc < 11);
            end else begin
                stall         = ($urandom_range(3, 0) == 0);
                imem_busywait = ($urandom_range(4, 0) < 2);
                branch_taken  = ($urandom_range(11, 0) == 0);
                branch_target = pick_target();
            end
            model_step();
        end
        @(negedge clk);
        check_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
